bridge_lowering: RTL and testbench
==================================

# bridge_lowering

Drawbridge lowering controller: the counterpart to the lifting controller in the drawbridge design. It takes the deck from fully upright to locked-down and hands the road back to traffic. A Moore FSM drives the deck motor (MT), the warning alarm (AL) and the road traffic light (TFL) from the same six deck sensors the lifting controller uses, plus lower-request and fault-clear inputs. It adds a pre-motion warning period, a motion timeout and a post-motion settle check.

## Interface
- SETTLE_CYCLES, 4: length, in cycles, of the WARN and SETTLE dwell periods (≥1)
- TIMEOUT_CYCLES, 64: maximum number of cycles in LOWERING before a fault (≥2)
- CW, 8: counter width; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES)-1

- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  lower request, level-sampled
- Clear  in  1  fault acknowledge
- S1  in  1  obstruction under deck (boat/vessel present)
- S2  in  1  deck fully-upright limit switch
- S3  in  1  deck fully-down limit switch
- S4  in  1  deck mid-travel sensor (status only, no transition effect)
- S5  in  1  emergency stop
- S6  in  1  mechanism fault (wind/overload)
- MT  out  1  motor run (lowering direction)
- AL  out  1  warning alarm
- TFL  out  1  traffic light: 1 = road closed (red), 0 = road open
- Done  out  1  one-cycle pulse when the deck reaches DOWN
- State  out  3  current state code, for debug

## Operation
- State codes: UPRIGHT=0, WARN=1, LOWERING=2, SETTLE=3, DOWN=4, FAULT=5; codes 6–7 are illegal and go to FAULT on the next edge.
- Outputs are registered and decoded from the state being entered, so they change on the same edge as State.

Output values per state (MT/AL/TFL):
- UPRIGHT 0/0/1
- WARN 0/1/1
- LOWERING 1/1/1
- SETTLE 0/0/1
- DOWN 0/0/0
- FAULT 0/1/1

Counter:
- Cleared to 0 on entry to WARN, LOWERING and SETTLE.
- Increments by 1 each cycle while in those states.
- Stays at 0 in all other states.

Transitions (listed in priority order within each state):
- UPRIGHT:
  - Start & S2 & !S1 & !S5 & !S6 → WARN.
  - Start under any other condition is ignored; stay in UPRIGHT.
- WARN:
  - S5|S6 → FAULT.
  - S1 → UPRIGHT (abort; deck has not moved).
  - count == SETTLE_CYCLES-1 → LOWERING.
- LOWERING:
  - S5|S6|S1 → FAULT.
  - S3 → SETTLE.
  - count == TIMEOUT_CYCLES-1 → FAULT.
- SETTLE:
  - S5|S6 → FAULT.
  - !S3 → FAULT (lock lost).
  - count == SETTLE_CYCLES-1 → DOWN, with Done=1 for that one cycle.
- DOWN:
  - S2 → UPRIGHT (lifting controller has raised the deck).
  - Otherwise hold; S5/S6 have no effect in DOWN.
- FAULT:
  - Clear & !S5 & !S6 → UPRIGHT.
  - Clear while S5 or S6 is high is ignored.
- Start is not edge-detected. A held Start in UPRIGHT re-arms immediately once UPRIGHT is re-entered with the start conditions met.

## Timing
- Reset (asynchronous, any time, including mid-LOWERING): State=UPRIGHT, MT=0, AL=0, TFL=1, Done=0, counter=0. MT drops immediately, with no clock edge needed.
- Start is sampled at edge t. WARN begins and AL=1 from edge t.
- WARN lasts exactly SETTLE_CYCLES cycles. MT=1 from edge t+SETTLE_CYCLES.
- S3 sampled at edge u in LOWERING: MT=0 from edge u. DOWN and Done from edge u+SETTLE_CYCLES. TFL=0 from the same edge.
- Timeout: if S3 is never seen, FAULT at the edge where count reaches TIMEOUT_CYCLES-1, i.e. TIMEOUT_CYCLES cycles after entering LOWERING.
- S3 and timeout on the same edge: S3 wins (→ SETTLE).
- S1 and S3 on the same edge in LOWERING: FAULT wins.
- Inputs are assumed synchronous to Clock; the block has no internal synchronizers.

## Test plan
- Nominal, SETTLE_CYCLES=4: S2=1, pulse Start at edge 0 → AL=1 at edges 0–3; MT=1 from edge 4. Assert S3 at edge 10 → MT=0 at edge 10; Done=1 and TFL=0 at edge 14 only.
- Abort in WARN: S1=1 at edge 2 after Start → UPRIGHT at edge 2, AL=0, MT never 1.
- Timeout, TIMEOUT_CYCLES=64: S3 held 0 through LOWERING → FAULT 64 cycles after LOWERING entry; MT=0, AL=1. Clear with S5=1 is ignored; Clear with S5=0 → UPRIGHT.
- Lock loss: S3 drops on the 2nd cycle of SETTLE → FAULT, Done never asserted.
- Async reset mid-LOWERING: Reset asserted between edges → MT=0, TFL=1, State=0 before the next edge.
- Start rejected: Start with S2=0, or with S6=1 → stays UPRIGHT, outputs 0/0/1.

Source files
------------

// File: rtl/bridge_lowering_if.sv
// Signal bundle between the drawbridge lowering controller and its environment:
// sensor/request inputs toward the controller, motor/alarm/light/status outputs back.
interface bridge_lowering_if;
    logic       Start;
    logic       Clear;
    logic       S1;
    logic       S2;
    logic       S3;
    logic       S4;
    logic       S5;
    logic       S6;
    logic       MT;
    logic       AL;
    logic       TFL;
    logic       Done;
    logic [2:0] State;

    modport master (
        output Start, Clear, S1, S2, S3, S4, S5, S6,
        input  MT, AL, TFL, Done, State
    );

    modport slave (
        input  Start, Clear, S1, S2, S3, S4, S5, S6,
        output MT, AL, TFL, Done, State
    );
endinterface

// File: rtl/bridge_lowering.sv
// Drawbridge lowering controller: Moore FSM taking the deck from upright to locked-down,
// with a pre-motion warning dwell, a motion timeout and a post-motion settle check.
module bridge_lowering #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CW             = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    bridge_lowering_if.slave  bus
);

    localparam logic [2:0] UPRIGHT  = 3'd0;
    localparam logic [2:0] WARN     = 3'd1;
    localparam logic [2:0] LOWERING = 3'd2;
    localparam logic [2:0] SETTLE   = 3'd3;
    localparam logic [2:0] DOWN     = 3'd4;
    localparam logic [2:0] FAULT    = 3'd5;

    localparam logic [CW-1:0] DWELL_LAST   = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_r;
    logic [2:0]    next_state_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          mt_r;
    logic          al_r;
    logic          tfl_r;
    logic          done_r;
    logic [2:0]    out_next_s;
    logic          done_next_s;
    logic          timed_state_s;

    // {MT, AL, TFL} for a given state; illegal codes decode like FAULT
    function automatic logic [2:0] out_decode(input logic [2:0] st);
        case (st)
            UPRIGHT:  out_decode = 3'b001;
            WARN:     out_decode = 3'b011;
            LOWERING: out_decode = 3'b111;
            SETTLE:   out_decode = 3'b001;
            DOWN:     out_decode = 3'b000;
            FAULT:    out_decode = 3'b011;
            default:  out_decode = 3'b011;
        endcase
    endfunction

    // Next-state selection, priorities as listed per state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            UPRIGHT: begin
                if (bus.Start && bus.S2 && !bus.S1 && !bus.S5 && !bus.S6) next_state_s = WARN;
                else                                                       next_state_s = UPRIGHT;
            end
            WARN: begin
                if (bus.S5 || bus.S6)           next_state_s = FAULT;
                else if (bus.S1)                next_state_s = UPRIGHT;
                else if (count_r == DWELL_LAST) next_state_s = LOWERING;
                else                            next_state_s = WARN;
            end
            LOWERING: begin
                if (bus.S5 || bus.S6 || bus.S1)   next_state_s = FAULT;
                else if (bus.S3)                  next_state_s = SETTLE;
                else if (count_r == TIMEOUT_LAST) next_state_s = FAULT;
                else                              next_state_s = LOWERING;
            end
            SETTLE: begin
                if (bus.S5 || bus.S6)           next_state_s = FAULT;
                else if (!bus.S3)               next_state_s = FAULT;
                else if (count_r == DWELL_LAST) next_state_s = DOWN;
                else                            next_state_s = SETTLE;
            end
            DOWN: begin
                if (bus.S2) next_state_s = UPRIGHT;
                else        next_state_s = DOWN;
            end
            FAULT: begin
                if (bus.Clear && !bus.S5 && !bus.S6) next_state_s = UPRIGHT;
                else                                 next_state_s = FAULT;
            end
            default: next_state_s = FAULT;
        endcase
    end

    // Dwell/timeout counter runs only while staying in a timed state; any entry restarts it
    always_comb begin
        timed_state_s = (state_r == WARN) || (state_r == LOWERING) || (state_r == SETTLE);
        count_next_s  = {CW{1'b0}};
        if (timed_state_s && (next_state_s == state_r)) count_next_s = count_r + CW'(1);
        else                                            count_next_s = {CW{1'b0}};
    end

    // Output values are decoded from the state being entered so they move with State
    always_comb begin
        out_next_s  = out_decode(next_state_s);
        done_next_s = (state_r == SETTLE) && (next_state_s == DOWN);
    end

    // State, counter and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= UPRIGHT;
            count_r <= {CW{1'b0}};
            mt_r    <= 1'b0;
            al_r    <= 1'b0;
            tfl_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= count_next_s;
            mt_r    <= out_next_s[2];
            al_r    <= out_next_s[1];
            tfl_r   <= out_next_s[0];
            done_r  <= done_next_s;
        end
    end

    assign bus.MT    = mt_r;
    assign bus.AL    = al_r;
    assign bus.TFL   = tfl_r;
    assign bus.Done  = done_r;
    assign bus.State = state_r;

endmodule

// File: tb/tb_bridge_lowering.sv
// Directed bench for bridge_lowering: per-edge vector table plus hand sequences
// for reset, timeout, timeout-vs-S3 race and asynchronous reset mid-motion.
module tb_bridge_lowering;

    localparam int SC = 4;
    localparam int TC = 64;

    logic Clock;
    logic Reset;
    int   n_cmp;
    int   n_err;

    bridge_lowering_if bus ();

    bridge_lowering #(.SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC), .CW(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // s = {S6,S5,S4,S3,S2,S1}; o = {MT,AL,TFL,Done}
    typedef struct {
        logic       start;
        logic       clear;
        logic [5:0] s;
        logic [2:0] st;
        logic [3:0] o;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic start, input logic clear, input logic [5:0] s,
                                input logic [2:0] st, input logic [3:0] o);
        vec_t v;
        v.start = start; v.clear = clear; v.s = s; v.st = st; v.o = o;
        return v;
    endfunction

    task automatic drive(input logic start, input logic clear, input logic [5:0] s);
        bus.Start = start; bus.Clear = clear;
        bus.S6 = s[5]; bus.S5 = s[4]; bus.S4 = s[3];
        bus.S3 = s[2]; bus.S2 = s[1]; bus.S1 = s[0];
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [3:0] o);
        logic [6:0] act;
        logic [6:0] exp;
        act = {bus.State, bus.MT, bus.AL, bus.TFL, bus.Done};
        exp = {st, o};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d MT/AL/TFL/Done=%b, expected state=%0d MT/AL/TFL/Done=%b",
                     name, act[6:4], act[3:0], exp[6:4], exp[3:0]);
        end
    endtask

    task automatic step(input logic start, input logic clear, input logic [5:0] s);
        @(negedge Clock);
        drive(start, clear, s);
        @(posedge Clock);
        #1;
    endtask

    // Start from UPRIGHT and run through WARN into LOWERING
    task automatic to_lowering(input string name);
        step(1'b1, 1'b0, 6'b000010);
        check({name, "_warn0"}, 3'd1, 4'b0110);
        for (int i = 1; i < SC; i++) step(1'b0, 1'b0, 6'b000010);
        check({name, "_warn_end"}, 3'd1, 4'b0110);
        step(1'b0, 1'b0, 6'b000000);
        check({name, "_lower_entry"}, 3'd2, 4'b1110);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 6'b000000);

        // nominal lowering: Start at edge 0, S3 at edge 10, Done at edge 14
        vecs.push_back(mk(1'b1, 1'b0, 6'b000010, 3'd1, 4'b0110));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd1, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd2, 4'b1110));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 3'd2, 4'b1110));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b0, 1'b0, 6'b000100, 3'd3, 4'b0010));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000100, 3'd4, 4'b0001));
        vecs.push_back(mk(1'b0, 1'b0, 6'b010100, 3'd4, 4'b0000));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd0, 4'b0010));
        // abort in WARN on S1
        vecs.push_back(mk(1'b1, 1'b0, 6'b000010, 3'd1, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd1, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000011, 3'd0, 4'b0010));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd0, 4'b0010));
        // rejected starts
        vecs.push_back(mk(1'b1, 1'b0, 6'b000000, 3'd0, 4'b0010));
        vecs.push_back(mk(1'b1, 1'b0, 6'b100010, 3'd0, 4'b0010));
        vecs.push_back(mk(1'b1, 1'b0, 6'b010010, 3'd0, 4'b0010));
        // lock loss in SETTLE, then fault clear handling and held-Start re-arm
        vecs.push_back(mk(1'b1, 1'b0, 6'b000010, 3'd1, 4'b0110));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd1, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 3'd2, 4'b1110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000100, 3'd3, 4'b0010));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000100, 3'd3, 4'b0010));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 3'd5, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b1, 6'b010000, 3'd5, 4'b0110));
        vecs.push_back(mk(1'b1, 1'b1, 6'b000010, 3'd0, 4'b0010));
        vecs.push_back(mk(1'b1, 1'b0, 6'b000010, 3'd1, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b010010, 3'd5, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b1, 6'b000010, 3'd0, 4'b0010));
        // S1 and S3 together in LOWERING: fault wins
        vecs.push_back(mk(1'b1, 1'b0, 6'b000010, 3'd1, 4'b0110));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 6'b000010, 3'd1, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 3'd2, 4'b1110));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000101, 3'd5, 4'b0110));
        vecs.push_back(mk(1'b0, 1'b1, 6'b000000, 3'd0, 4'b0010));

        #2;
        check("reset_state", 3'd0, 4'b0010);
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].clear, vecs[i].s);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].o);
        end

        // timeout: FAULT exactly TC edges after LOWERING entry
        to_lowering("tmo");
        for (int i = 1; i < TC; i++) step(1'b0, 1'b0, 6'b000000);
        check("tmo_last_lowering", 3'd2, 4'b1110);
        step(1'b0, 1'b0, 6'b000000);
        check("tmo_fault", 3'd5, 4'b0110);
        step(1'b0, 1'b1, 6'b010000);
        check("tmo_clear_blocked", 3'd5, 4'b0110);
        step(1'b0, 1'b1, 6'b000000);
        check("tmo_clear", 3'd0, 4'b0010);

        // S3 on the timeout edge: SETTLE wins
        to_lowering("race");
        for (int i = 1; i < TC; i++) step(1'b0, 1'b0, 6'b000000);
        step(1'b0, 1'b0, 6'b000100);
        check("race_settle", 3'd3, 4'b0010);
        for (int i = 1; i < SC; i++) step(1'b0, 1'b0, 6'b000100);
        check("race_settle_end", 3'd3, 4'b0010);
        step(1'b0, 1'b0, 6'b000100);
        check("race_down", 3'd4, 4'b0001);
        step(1'b0, 1'b0, 6'b000010);
        check("race_lifted", 3'd0, 4'b0010);

        // asynchronous reset between edges during LOWERING
        to_lowering("arst");
        step(1'b0, 1'b0, 6'b000000);
        check("arst_pre", 3'd2, 4'b1110);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_async", 3'd0, 4'b0010);
        @(negedge Clock);
        Reset = 1'b0;
        step(1'b0, 1'b0, 6'b000000);
        check("arst_after", 3'd0, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
